// File: rtl/johnson_ctr_pkg.sv
// Shared mode encoding and state-legality helpers for the Johnson/ring counter.
// Helpers take a zero-extended state and the live width so one body serves every WIDTH.
package johnson_ctr_pkg;

   localparam int unsigned MAX_WIDTH = 32;

   typedef enum logic {
      MODE_JOHNSON = 1'b0,
      MODE_RING    = 1'b1
   } mode_e;

   // Ones in the low `width` bits; width must be 1..MAX_WIDTH.
   function automatic logic [MAX_WIDTH-1:0] width_mask(input int unsigned width);
      return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
   endfunction

   // Legal Johnson codes are a run of ones anchored at bit 0 or, inverted, at the MSB.
   function automatic logic is_johnson_legal(input logic [MAX_WIDTH-1:0] state,
                                             input int unsigned          width);
      logic [MAX_WIDTH-1:0] mask;
      logic [MAX_WIDTH-1:0] lo;
      logic [MAX_WIDTH-1:0] hi;
      mask = width_mask(width);
      lo   = state & mask;
      hi   = ~state & mask;
      return ((lo & (lo + MAX_WIDTH'(1))) == '0) || ((hi & (hi + MAX_WIDTH'(1))) == '0);
   endfunction

   function automatic logic is_onehot(input logic [MAX_WIDTH-1:0] state);
      return (state != '0) && ((state & (state - MAX_WIDTH'(1))) == '0);
   endfunction

endpackage

// File: rtl/johnson_ctr_next.sv
// Next-state logic for johnson_ctr: shift rules for both modes plus one-clock
// correction of any illegal code to the mode's reset-like state.
module johnson_ctr_next
   import johnson_ctr_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] cur_i,
   input  logic             mode_i,
   output logic [WIDTH-1:0] nxt_c
);

   logic [MAX_WIDTH-1:0] cur_ext;
   logic                 j_legal;
   logic                 r_legal;

   always_comb begin
      cur_ext = MAX_WIDTH'(cur_i);
      j_legal = is_johnson_legal(cur_ext, WIDTH);
      r_legal = is_onehot(cur_ext);
   end

   // Twisted shift in Johnson mode, plain rotate in ring mode.
   always_comb begin
      nxt_c = '0;
      if (mode_i == MODE_RING) begin
         if (r_legal) nxt_c = {cur_i[WIDTH-2:0], cur_i[WIDTH-1]};
         else         nxt_c = WIDTH'(1);
      end else begin
         if (j_legal) nxt_c = {cur_i[WIDTH-2:0], ~cur_i[WIDTH-1]};
         else         nxt_c = '0;
      end
   end

endmodule

// File: rtl/johnson_ctr.sv
// Johnson / one-hot ring counter: state register with async active-low reset;
// all sequencing lives in johnson_ctr_next.
module johnson_ctr
   import johnson_ctr_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             c,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] out_q;
   logic [WIDTH-1:0] out_d;
   logic [WIDTH-1:0] nxt_c;

   johnson_ctr_next #(
      .WIDTH (WIDTH)
   ) u_next (
      .cur_i  (out_q),
      .mode_i (c),
      .nxt_c  (nxt_c)
   );

   always_comb begin
      out_d = nxt_c;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) out_q <= '0;
      else       out_q <= out_d;
   end

   assign out = out_q;

endmodule

// File: tb/tb_johnson_ctr.sv
// Scoreboard bench for johnson_ctr at WIDTH=4 (mode driven) and WIDTH=3 (Johnson only),
// against a sequence-table / bit-position reference model.
module tb_johnson_ctr;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       c = 1'b0;
   logic       c3 = 1'b0;
   logic [3:0] out4;
   logic [2:0] out3;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0] e4;
      logic [2:0] e3;
   } exp_t;

   exp_t       sb_q[$];
   logic [31:0] m4 = '0;
   logic [31:0] m3 = '0;

   always #5 clk = ~clk;

   johnson_ctr #(.WIDTH(4)) dut4 (.clk(clk), .rstn(rstn), .c(c),  .out(out4));
   johnson_ctr #(.WIDTH(3)) dut3 (.clk(clk), .rstn(rstn), .c(c3), .out(out3));

   // Entry i of the Johnson cycle: i ones filling from bit 0, then zeros filling from bit 0.
   function automatic logic [31:0] jseq(input int i, input int w);
      logic [31:0] mask;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      if (i <= w) return (i >= 32) ? 32'hFFFF_FFFF : ((32'd1 << i) - 32'd1);
      return mask & ~((32'd1 << (i - w)) - 32'd1);
   endfunction

   function automatic logic [31:0] ref_next(input logic [31:0] s, input logic mode, input int w);
      int cnt;
      int pos;
      if (!mode) begin
         for (int i = 0; i < 2*w; i++)
            if (jseq(i, w) == s) return jseq((i + 1) % (2*w), w);
         return 32'd0;
      end
      cnt = 0;
      pos = 0;
      for (int i = 0; i < w; i++)
         if (s[i]) begin cnt++; pos = i; end
      if (cnt == 1) return 32'd1 << ((pos + 1) % w);
      return 32'd1;
   endfunction

   task automatic push_exp();
      exp_t e;
      e.e4 = m4[3:0];
      e.e3 = m3[2:0];
      sb_q.push_back(e);
   endtask

   // Drive one cycle of inputs at the falling edge and record the post-edge expectation.
   task automatic step(input logic cv, input logic rv);
      @(negedge clk);
      c    = cv;
      rstn = rv;
      if (!rv) begin
         m4 = '0;
         m3 = '0;
      end else begin
         m4 = ref_next(m4, cv, 4);
         m3 = ref_next(m3, 1'b0, 3);
      end
      push_exp();
   endtask

   task automatic async_reset_check();
      @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      checks++;
      if (out4 !== 4'b0000 || out3 !== 3'b000) begin
         errors++;
         $display("FAIL async_reset: out4=%b out3=%b required 0000/000", out4, out3);
      end
      m4 = '0;
      m3 = '0;
      push_exp();
   endtask

   // Monitor: every state update is compared against the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (out4 !== e.e4) begin
               errors++;
               $display("FAIL out4 at %0t: got %b required %b (c=%b rstn=%b)", $time, out4, e.e4, c, rstn);
            end
            checks++;
            if (out3 !== e.e3) begin
               errors++;
               $display("FAIL out3 at %0t: got %b required %b", $time, out3, e.e3);
            end
         end
      end
   end

   initial begin
      int waited;
      #1;
      checks++;
      if (out4 !== 4'b0000 || out3 !== 3'b000) begin
         errors++;
         $display("FAIL reset_state: out4=%b out3=%b required 0000/000", out4, out3);
      end

      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      repeat (16) step(1'b0, 1'b1);
      repeat (5)  step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      repeat (4) step(1'b0, 1'b1);
      async_reset_check();
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      repeat (6) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);

      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 40) == 0) async_reset_check();
         else step(1'b0 | 1'($urandom_range(0, 1)), ($urandom_range(0, 15) != 0));
      end
      step(1'b0, 1'b1);

      waited = 0;
      while (sb_q.size() > 0 && waited < 20) begin
         @(posedge clk);
         waited++;
      end
      #2;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
